fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction prefetch queue between the instruction source and the IF/ID pipeline register.
- Generates sequential fetch addresses and issues them to an instruction memory port with a variable-latency req/ack handshake.
- Buffers returned {pc, instruction} pairs in a small FIFO and presents the head entry to IF/ID.
- On a branch/jump redirect, flushes buffered and in-flight instructions and restarts fetch at the target.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- mem_req  output  1  fetch request; held high until acknowledged.
- mem_addr  output  32  fetch address; stable while mem_req is high.
- mem_ack  input  1  memory returns mem_rdata this cycle; ignored when mem_req is low.
- mem_rdata  input  32  instruction word, valid with mem_ack.
- deq  input  1  IF/ID consumes the head entry this cycle (IFIDWrite & PCWrite from hazard unit).
- redirect  input  1  branch/jump taken; flush and refetch.
- redirect_pc  input  32  target address, valid with redirect.
- out_valid  output  1  head entry valid.
- out_pc  output  32  pc of head entry.
- out_instru  output  32  instruction of head entry.
- count  output  log2(DEPTH)+1  number of valid entries.

Behaviour:
- Reset (rst high at an edge):
  - fetch_pc=RESET_PC, count=0, read/write pointers=0, state=IDLE.
  - mem_req=0, mem_addr=RESET_PC, out_valid=0, out_pc=0, out_instru=0.
  - rst has priority over every other input.
- State machine (mem_req and mem_addr are registered):
  - IDLE: if count_next<DEPTH, go to WAIT with mem_req=1, mem_addr=fetch_pc.
  - WAIT, mem_ack=1: push {mem_addr, mem_rdata}; fetch_pc=mem_addr+4.
    - If count_next<DEPTH: stay WAIT, mem_addr=mem_addr+4 (back-to-back, one fetch per cycle with single-cycle ack).
    - Else: go to IDLE, mem_req=0.
  - WAIT, mem_ack=0: hold mem_req and mem_addr.
  - DISCARD: an abandoned request is in flight; mem_req and mem_addr stay held.
    - On mem_ack: drop data, go to IDLE, mem_req=0.
- count_next = count + push - pop, where pop = deq & out_valid.
- At most one request outstanding. No push ever occurs with count==DEPTH.
- FIFO:
  - out_valid = (count!=0).
  - out_pc/out_instru are driven from the head entry (combinational read of registered storage); 0 when empty.
  - deq with count==0 is ignored.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
- Redirect (higher priority than push/deq):
  - count=0, pointers reset, fetch_pc=redirect_pc.
  - From IDLE: go IDLE (request issues next cycle).
  - From WAIT, mem_ack=1 same cycle: data dropped; go IDLE.
  - From WAIT, mem_ack=0: go DISCARD.
  - From DISCARD, mem_ack=0: stay DISCARD; fetch_pc takes the newest redirect_pc.
  - From DISCARD, mem_ack=1 same cycle: drop data; go IDLE.
  - deq in the same cycle as redirect has no effect.
- Latency:
  - With mem_ack tied high, the first entry is visible out_valid two edges after rst deasserts (edge1 issue, edge2 push).
  - After a redirect, the target instruction is at the head no earlier than edge+2.
- Arithmetic: fetch_pc and mem_addr increment by 4 modulo 2^32; 32'hFFFF_FFFC wraps to 0.

Test Plan:
- Reset, mem_ack=1, deq=0 -> mem_addr 0,4,8,12 acked on consecutive cycles; count reaches 4, then mem_req=0; out_pc=0, out_instru=word@0.
- Full queue, deq=1 for one cycle with mem_ack=1 -> count 4->3, mem_req rises next cycle at addr 16; count returns to 4 with entry pc=16 at tail.
- Steady state, deq=1 and mem_ack=1 every cycle -> count constant; out_pc increments by 4 each cycle with no gaps.
- mem_ack delayed 3 cycles -> mem_addr stable and mem_req high throughout; exactly one push on the ack edge.
- redirect to 0x100 while WAIT on addr 8 with ack delayed 2 cycles -> count=0 immediately; stale ack data dropped; next request addr 0x100; out_pc=0x100.
- redirect with simultaneous mem_ack and deq -> no push, no pop; count=0; next mem_addr=redirect_pc. Also: rst asserted mid-WAIT -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential fetches over a req/ack port,
// buffers {pc, instruction} pairs and flushes/refetches on redirect.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_ack,
  input  logic [31:0]              mem_rdata,
  input  logic                     deq,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instru,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t         state_q;
  logic [31:0]    fetch_pc_q;
  logic           mem_req_q;
  logic [31:0]    mem_addr_q;
  logic [CW-1:0]  count_q;
  logic [CW-1:0]  count_d;
  logic [PW-1:0]  rptr_q;
  logic [PW-1:0]  wptr_q;
  logic           push;
  logic           pop;

  logic [31:0]    pc_mem  [DEPTH];
  logic [31:0]    ins_mem [DEPTH];

  // Redirect overrides both push and pop; DISCARD acks never push.
  always_comb begin
    push    = 1'b0;
    pop     = 1'b0;
    count_d = count_q;
    if (redirect) begin
      count_d = '0;
    end else begin
      push    = (state_q == WAIT) && mem_ack;
      pop     = deq && (count_q != '0);
      count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wptr_q]  <= mem_addr_q;
      ins_mem[wptr_q] <= mem_rdata;
    end
  end

  // Fetch FSM, pointers and occupancy; mem_req/mem_addr are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      count_q    <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
    end else begin
      count_q <= count_d;
      if (redirect) begin
        rptr_q <= '0;
        wptr_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + {{(PW-1){1'b0}}, 1'b1};
        if (pop)  rptr_q <= rptr_q + {{(PW-1){1'b0}}, 1'b1};
      end

      case (state_q)
        IDLE: begin
          if (redirect) begin
            fetch_pc_q <= redirect_pc;
          end else if (count_d < FULL) begin
            state_q    <= WAIT;
            mem_req_q  <= 1'b1;
            mem_addr_q <= fetch_pc_q;
          end
        end
        WAIT: begin
          if (redirect) begin
            fetch_pc_q <= redirect_pc;
            if (mem_ack) begin
              state_q   <= IDLE;
              mem_req_q <= 1'b0;
            end else begin
              state_q <= DISCARD;
            end
          end else if (mem_ack) begin
            fetch_pc_q <= mem_addr_q + 32'd4;
            if (count_d < FULL) begin
              mem_addr_q <= mem_addr_q + 32'd4;
            end else begin
              state_q   <= IDLE;
              mem_req_q <= 1'b0;
            end
          end
        end
        DISCARD: begin
          // The abandoned request must complete before a new one may issue.
          if (redirect) fetch_pc_q <= redirect_pc;
          if (mem_ack) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign count      = count_q;
  assign out_valid  = (count_q != '0);
  assign out_pc     = out_valid ? pc_mem[rptr_q]  : 32'h0000_0000;
  assign out_instru = out_valid ? ins_mem[rptr_q] : 32'h0000_0000;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue; memory returns addr ^ 32'hCAFE_0000.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        deq;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instru;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .deq(deq), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_pc(out_pc), .out_instru(out_instru), .count(count)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_addr ^ 32'hCAFE_0000;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b1; deq = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    step(); step();
    chk("rst_req",   {31'd0, mem_req},   32'd0);
    chk("rst_addr",  mem_addr,           32'h0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_pc",    out_pc,             32'h0);
    chk("rst_ins",   out_instru,         32'h0);
    chk("rst_cnt",   {29'd0, count},     32'd0);

    // Fill with single-cycle acks.
    rst = 1'b0;
    step();
    chk("f1_req",  {31'd0, mem_req}, 32'd1);
    chk("f1_addr", mem_addr,         32'h0);
    chk("f1_cnt",  {29'd0, count},   32'd0);
    step();
    chk("f2_cnt",   {29'd0, count},   32'd1);
    chk("f2_valid", {31'd0, out_valid}, 32'd1);
    chk("f2_pc",    out_pc,           32'h0);
    chk("f2_ins",   out_instru,       32'hCAFE_0000);
    chk("f2_addr",  mem_addr,         32'h4);
    step();
    chk("f3_addr", mem_addr, 32'h8);
    step();
    chk("f4_addr", mem_addr, 32'hC);
    step();
    chk("f5_cnt", {29'd0, count},   32'd4);
    chk("f5_req", {31'd0, mem_req}, 32'd0);
    step();
    chk("f6_cnt", {29'd0, count},   32'd4);
    chk("f6_req", {31'd0, mem_req}, 32'd0);
    chk("f6_pc",  out_pc,           32'h0);

    // One dequeue from full.
    deq = 1'b1;
    step();
    chk("d1_cnt",  {29'd0, count},   32'd3);
    chk("d1_req",  {31'd0, mem_req}, 32'd1);
    chk("d1_addr", mem_addr,         32'h10);
    chk("d1_pc",   out_pc,           32'h4);
    deq = 1'b0;
    step();
    chk("d2_cnt", {29'd0, count},   32'd4);
    chk("d2_req", {31'd0, mem_req}, 32'd0);

    // Steady state: dequeue every cycle, head advances by 4 (reaches pc 16 at the tail).
    deq = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("ss_pc",  out_pc,         32'h8 + 32'(4 * k));
      chk("ss_cnt", {29'd0, count}, 32'd3);
    end
    chk("ss_ins", out_instru, 32'hCAFE_0014);

    // Ack delayed three cycles.
    deq = 1'b0; mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("dl_req",  {31'd0, mem_req}, 32'd1);
      chk("dl_addr", mem_addr,         32'h20);
      chk("dl_cnt",  {29'd0, count},   32'd3);
    end
    mem_ack = 1'b1;
    step();
    chk("dl_push", {29'd0, count},   32'd4);
    chk("dl_idle", {31'd0, mem_req}, 32'd0);
    step();
    chk("dl_once", {29'd0, count}, 32'd4);

    // Redirect while waiting on addr 8.
    rst = 1'b1; step(); rst = 1'b0;
    step(); step(); step();
    chk("rd_addr8", mem_addr, 32'h8);
    mem_ack = 1'b0;
    step();
    chk("rd_hold", {29'd0, count}, 32'd2);
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    chk("rd_cnt0",  {29'd0, count},     32'd0);
    chk("rd_val0",  {31'd0, out_valid}, 32'd0);
    chk("rd_dreq",  {31'd0, mem_req},   32'd1);
    chk("rd_daddr", mem_addr,           32'h8);
    step();
    chk("rd_dreq2", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1;
    step();
    chk("rd_drop", {29'd0, count},   32'd0);
    chk("rd_idle", {31'd0, mem_req}, 32'd0);
    step();
    chk("rd_naddr", mem_addr,         32'h100);
    chk("rd_nreq",  {31'd0, mem_req}, 32'd1);
    step();
    chk("rd_cnt1", {29'd0, count}, 32'd1);
    chk("rd_pc",   out_pc,         32'h100);
    chk("rd_ins",  out_instru,     32'hCAFE_0100);

    // Redirect with simultaneous ack and deq.
    redirect = 1'b1; redirect_pc = 32'h200; deq = 1'b1;
    step();
    redirect = 1'b0; deq = 1'b0;
    chk("ra_cnt", {29'd0, count},     32'd0);
    chk("ra_val", {31'd0, out_valid}, 32'd0);
    chk("ra_req", {31'd0, mem_req},   32'd0);
    step();
    chk("ra_addr", mem_addr,         32'h200);
    chk("ra_nreq", {31'd0, mem_req}, 32'd1);

    // Reset in the middle of a wait.
    mem_ack = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("mr_req",  {31'd0, mem_req},   32'd0);
    chk("mr_addr", mem_addr,           32'h0);
    chk("mr_cnt",  {29'd0, count},     32'd0);
    chk("mr_val",  {31'd0, out_valid}, 32'd0);
    chk("mr_pc",   out_pc,             32'h0);
    chk("mr_ins",  out_instru,         32'h0);

    // Address wrap past 32'hFFFF_FFFC.
    rst = 1'b0; mem_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    chk("wr_idle", {31'd0, mem_req}, 32'd0);
    step();
    chk("wr_a0", mem_addr, 32'hFFFF_FFF8);
    step();
    chk("wr_a1", mem_addr, 32'hFFFF_FFFC);
    step();
    chk("wr_a2", mem_addr, 32'h0000_0000);
    chk("wr_pc", out_pc,   32'hFFFF_FFF8);
    step();
    chk("wr_cnt", {29'd0, count}, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
